uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_frame_pkg.sv | 24 ++
 rtl/uart_cmd_parser.sv | 171 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - frame constants and parser state encoding for uart_cmd_parser
//
// Purpose: shared definitions for the UART command frame:
//   header bytes, command codes, CFG payload length and FSM state encoding.
package uart_frame_pkg;

    localparam logic [7:0] HDR_BYTE0 = 8'h55;
    localparam logic [7:0] HDR_BYTE1 = 8'hAA;

    localparam logic [2:0] CMD_CFG = 3'd1;

    // CFG payload: trans_length, sampling_rate, sampling_num, 16 bits each, MSB first
    localparam logic [2:0] PAYLOAD_LEN = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR2    = 3'd1,
        ADDR    = 3'd2,
        FUNC    = 3'd3,
        PAYLOAD = 3'd4,
        CHK     = 3'd5
    } state_t;

endpackage

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - byte-stream command frame parser with checksum, addressing and timeout
//
// Purpose: parses frames 55 AA ADDR FUNC [6 payload bytes when CFG] CHK from a
//   byte strobe stream, emits accepted commands and holds the CFG configuration.
// Ports:
//   I_clk            in   1   clock, rising edge
//   I_rst            in   1   synchronous active-high reset
//   I_rx_data_valid  in   1   byte strobe
//   I_rx_data        in   8   received byte
//   I_device_addr    in   8   this unit's address
//   O_cmd_valid      out  1   one-cycle strobe, accepted command
//   O_cmd_data       out  3   command code of the accepted frame
//   O_trans_length   out  16  configured transfer length
//   O_sampling_rate  out  16  configured sampling rate
//   O_sampling_num   out  16  configured sample count
//   O_frame_err      out  1   one-cycle strobe, bad checksum or inter-byte timeout
import uart_frame_pkg::*;

module uart_cmd_parser #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000,
    parameter logic [7:0]  BCAST_ADDR     = 8'hFF,
    parameter logic [15:0] DEF_TRANS_LEN  = 16'd1024,
    parameter logic [15:0] DEF_SAMP_RATE  = 16'd1000,
    parameter logic [15:0] DEF_SAMP_NUM   = 16'd1024
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_rx_data_valid,
    input  logic [7:0]  I_rx_data,
    input  logic [7:0]  I_device_addr,
    output logic        O_cmd_valid,
    output logic [2:0]  O_cmd_data,
    output logic [15:0] O_trans_length,
    output logic [15:0] O_sampling_rate,
    output logic [15:0] O_sampling_num,
    output logic        O_frame_err
);

    state_t      state, state_next;
    logic [19:0] timeout_cnt, timeout_cnt_next;
    logic [2:0]  payload_cnt, payload_cnt_next;
    logic [7:0]  chk_acc, chk_acc_next;
    logic        addr_match, addr_match_next;
    logic [2:0]  cmd_reg, cmd_reg_next;
    logic [47:0] shadow, shadow_next;

    logic        cmd_valid_next;
    logic [2:0]  cmd_data_next;
    logic        frame_err_next;
    logic [15:0] trans_length_next, sampling_rate_next, sampling_num_next;
    logic        timeout_fire;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state           <= IDLE;
            timeout_cnt     <= '0;
            payload_cnt     <= '0;
            chk_acc         <= '0;
            addr_match      <= 1'b0;
            cmd_reg         <= '0;
            shadow          <= '0;
            O_cmd_valid     <= 1'b0;
            O_cmd_data      <= 3'd0;
            O_frame_err     <= 1'b0;
            O_trans_length  <= DEF_TRANS_LEN;
            O_sampling_rate <= DEF_SAMP_RATE;
            O_sampling_num  <= DEF_SAMP_NUM;
        end else begin
            state           <= state_next;
            timeout_cnt     <= timeout_cnt_next;
            payload_cnt     <= payload_cnt_next;
            chk_acc         <= chk_acc_next;
            addr_match      <= addr_match_next;
            cmd_reg         <= cmd_reg_next;
            shadow          <= shadow_next;
            O_cmd_valid     <= cmd_valid_next;
            O_cmd_data      <= cmd_data_next;
            O_frame_err     <= frame_err_next;
            O_trans_length  <= trans_length_next;
            O_sampling_rate <= sampling_rate_next;
            O_sampling_num  <= sampling_num_next;
        end
    end

    // Timeout wins over a byte arriving in the same cycle: that byte is dropped.
    assign timeout_fire = (state != IDLE) && (timeout_cnt >= TIMEOUT_CYCLES);

    always_comb begin
        state_next         = state;
        payload_cnt_next   = payload_cnt;
        chk_acc_next       = chk_acc;
        addr_match_next    = addr_match;
        cmd_reg_next       = cmd_reg;
        shadow_next        = shadow;
        cmd_valid_next     = 1'b0;
        cmd_data_next      = O_cmd_data;
        frame_err_next     = 1'b0;
        trans_length_next  = O_trans_length;
        sampling_rate_next = O_sampling_rate;
        sampling_num_next  = O_sampling_num;

        if (state == IDLE || I_rx_data_valid) begin
            timeout_cnt_next = '0;
        end else begin
            timeout_cnt_next = timeout_cnt + 20'd1;
        end

        if (timeout_fire) begin
            state_next       = IDLE;
            timeout_cnt_next = '0;
            payload_cnt_next = '0;
            frame_err_next   = 1'b1;
        end else if (I_rx_data_valid) begin
            case (state)
                IDLE: begin
                    if (I_rx_data == HDR_BYTE0) begin
                        state_next = HDR2;
                    end
                end
                HDR2: begin
                    if (I_rx_data == HDR_BYTE1) begin
                        state_next   = ADDR;
                        chk_acc_next = '0;
                    end else if (I_rx_data != HDR_BYTE0) begin
                        state_next = IDLE;
                    end
                end
                ADDR: begin
                    chk_acc_next    = chk_acc + I_rx_data;
                    addr_match_next = (I_rx_data == I_device_addr) || (I_rx_data == BCAST_ADDR);
                    state_next      = FUNC;
                end
                FUNC: begin
                    chk_acc_next     = chk_acc + I_rx_data;
                    cmd_reg_next     = I_rx_data[2:0];
                    payload_cnt_next = '0;
                    state_next       = (I_rx_data[2:0] == CMD_CFG) ? PAYLOAD : CHK;
                end
                PAYLOAD: begin
                    chk_acc_next = chk_acc + I_rx_data;
                    shadow_next  = {shadow[39:0], I_rx_data};
                    if (payload_cnt == PAYLOAD_LEN - 3'd1) begin
                        payload_cnt_next = '0;
                        state_next       = CHK;
                    end else begin
                        payload_cnt_next = payload_cnt + 3'd1;
                    end
                end
                CHK: begin
                    state_next = IDLE;
                    if (I_rx_data != chk_acc) begin
                        frame_err_next = 1'b1;
                    end else if (addr_match) begin
                        cmd_valid_next = 1'b1;
                        cmd_data_next  = cmd_reg;
                        // Configuration commits only on an accepted CFG frame, all three at once.
                        if (cmd_reg == CMD_CFG) begin
                            trans_length_next  = shadow[47:32];
                            sampling_rate_next = shadow[31:16];
                            sampling_num_next  = shadow[15:0];
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking scoreboard bench for uart_cmd_parser
module tb_uart_cmd_parser;

    localparam logic [15:0] D_TL = 16'd1024;
    localparam logic [15:0] D_SR = 16'd1000;
    localparam logic [15:0] D_SN = 16'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  dev_addr;
    logic        cmd_valid;
    logic [2:0]  cmd_data;
    logic [15:0] trans_length, sampling_rate, sampling_num;
    logic        frame_err;

    typedef struct {
        logic        is_err;
        logic [2:0]  cmd;
        logic [15:0] tl;
        logic [15:0] sr;
        logic [15:0] sn;
    } exp_t;

    exp_t sb[$];
    logic [15:0] m_tl = D_TL, m_sr = D_SR, m_sn = D_SN;
    int n_checks = 0;
    int n_pass = 0;

    uart_cmd_parser #(
        .TIMEOUT_CYCLES(20'd16),
        .BCAST_ADDR(8'hFF),
        .DEF_TRANS_LEN(D_TL),
        .DEF_SAMP_RATE(D_SR),
        .DEF_SAMP_NUM(D_SN)
    ) dut (
        .I_clk(clk),
        .I_rst(rst),
        .I_rx_data_valid(rx_valid),
        .I_rx_data(rx_data),
        .I_device_addr(dev_addr),
        .O_cmd_valid(cmd_valid),
        .O_cmd_data(cmd_data),
        .O_trans_length(trans_length),
        .O_sampling_rate(sampling_rate),
        .O_sampling_num(sampling_num),
        .O_frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] calc_chk(input logic [7:0] a, input logic [7:0] f, input logic [47:0] pl);
        logic [7:0] s;
        s = a + f;
        if (f[2:0] == 3'd1) begin
            for (int i = 0; i < 6; i++) s = s + pl[47-8*i -: 8];
        end
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1; e.cmd = 3'd0; e.tl = m_tl; e.sr = m_sr; e.sn = m_sn;
        sb.push_back(e);
    endtask

    // Expectation is derived from the frame contents before the CHK byte is driven.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] f, input logic [47:0] pl, input logic [7:0] chk);
        exp_t e;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(a);
        send_byte(f);
        if (f[2:0] == 3'd1) begin
            for (int i = 0; i < 6; i++) send_byte(pl[47-8*i -: 8]);
        end
        if (chk != calc_chk(a, f, pl)) begin
            push_err();
        end else if (a == dev_addr || a == 8'hFF) begin
            if (f[2:0] == 3'd1) begin
                m_tl = pl[47:32]; m_sr = pl[31:16]; m_sn = pl[15:0];
            end
            e.is_err = 1'b0; e.cmd = f[2:0]; e.tl = m_tl; e.sr = m_sr; e.sn = m_sn;
            sb.push_back(e);
        end
        send_byte(chk);
    endtask

    task automatic check_cfg(input string tag);
        check({tag, "_tl"}, 48'(trans_length), 48'(m_tl));
        check({tag, "_sr"}, 48'(sampling_rate), 48'(m_sr));
        check({tag, "_sn"}, 48'(sampling_num), 48'(m_sn));
    endtask

    always @(negedge clk) begin
        if (cmd_valid || frame_err) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 48'({cmd_valid, frame_err}), 48'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind", 48'({cmd_valid, frame_err}), e.is_err ? 48'd1 : 48'd2);
                if (!e.is_err) check("cmd_data", 48'(cmd_data), 48'(e.cmd));
                check("strobe_tl", 48'(trans_length), 48'(e.tl));
                check("strobe_sr", 48'(sampling_rate), 48'(e.sr));
                check("strobe_sn", 48'(sampling_num), 48'(e.sn));
            end
        end
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; dev_addr = 8'h03;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_valid", 48'(cmd_valid), 48'd0);
        check("rst_frame_err", 48'(frame_err), 48'd0);
        check("rst_cmd_data", 48'(cmd_data), 48'd0);
        check_cfg("rst");
        rst = 1'b0;
        gap(2);

        // plain command, CFG, bad checksum
        send_frame(8'h03, 8'h02, 48'h0, 8'h05);
        send_frame(8'h03, 8'h01, 48'h0800_01F4_0400, 8'h05);
        gap(2);
        check_cfg("cfg1");
        send_frame(8'h03, 8'h02, 48'h0, 8'h06);
        gap(2);
        check_cfg("after_bad_chk");

        // address mismatch dropped, broadcast accepted
        send_frame(8'h07, 8'h02, 48'h0, 8'h09);
        send_frame(8'hFF, 8'h04, 48'h0, 8'h03);

        // back-to-back, upper FUNC bits ignored, broadcast CFG, foreign CFG dropped
        send_frame(8'h03, 8'hFA, 48'h0, 8'hFD);
        send_frame(8'h03, 8'h05, 48'h0, 8'h08);
        send_frame(8'hFF, 8'h01, 48'h1234_5678_9ABC, calc_chk(8'hFF, 8'h01, 48'h1234_5678_9ABC));
        send_frame(8'h07, 8'h01, 48'hDEAD_BEEF_0001, calc_chk(8'h07, 8'h01, 48'hDEAD_BEEF_0001));
        gap(2);
        check_cfg("after_foreign_cfg");

        // inter-byte timeout, then a normal frame
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
        push_err();
        gap(20);
        send_frame(8'h03, 8'h02, 48'h0, 8'h05);

        // byte arriving in the timeout cycle is discarded
        send_byte(8'h55); send_byte(8'hAA);
        push_err();
        gap(16);
        send_byte(8'h03); send_byte(8'h02); send_byte(8'h05);
        gap(3);

        // repeated header byte
        send_byte(8'h55);
        send_frame(8'h03, 8'h02, 48'h0, 8'h05);

        // reset mid-CFG payload
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01);
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h01);
        rst = 1'b1;
        gap(2);
        rst = 1'b0;
        m_tl = D_TL; m_sr = D_SR; m_sn = D_SN;
        check_cfg("after_mid_rst");
        send_byte(8'hF4); send_byte(8'h04); send_byte(8'h00);
        send_frame(8'h03, 8'h06, 48'h0, 8'h09);

        gap(5);
        check("sb_empty", 48'(sb.size()), 48'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
